// File: rtl/sorting_core_if.sv
// Streaming packet port of the sorter: input beats, sorted output beats
// and the busy indication.
interface sorting_core_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] data_i;
  logic              sop_i;
  logic              eop_i;
  logic              val_i;
  logic [DWIDTH-1:0] data_o;
  logic              sop_o;
  logic              eop_o;
  logic              val_o;
  logic              busy_o;

  modport master (
    output data_i, sop_i, eop_i, val_i,
    input  data_o, sop_o, eop_o, val_o, busy_o
  );

  modport slave (
    input  data_i, sop_i, eop_i, val_i,
    output data_o, sop_o, eop_o, val_o, busy_o
  );
endinterface

// File: rtl/sorting_core.sv
// Packet sorter: stores one sop/eop framed packet, bubble-sorts it in
// place ascending, then replays it with the same framing.
module sorting_core #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
) (
  input logic           clk_i,
  input logic           srst_i,
  sorting_core_if.slave bus
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [1:0] RECV = 2'd0;
  localparam logic [1:0] SORT = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [AWIDTH:0] N_MAX = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] ONE = {{AWIDTH{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH:0]   cnt;
  logic [AWIDTH:0]   idx;
  logic              open;
  logic              swapped;
  logic [DWIDTH-1:0] data_r;
  logic              sop_r;
  logic              eop_r;
  logic              val_r;
  logic              busy_r;

  logic [AWIDTH:0]   idx_n;
  logic [DWIDTH-1:0] lo_w;
  logic [DWIDTH-1:0] hi_w;
  logic              swap;
  logic              last;

  assign idx_n = idx + ONE;
  assign lo_w  = mem[idx[AWIDTH-1:0]];
  assign hi_w  = mem[idx_n[AWIDTH-1:0]];
  assign swap  = lo_w > hi_w;
  assign last  = idx_n == (cnt - ONE);

  assign bus.data_o = data_r;
  assign bus.sop_o  = sop_r;
  assign bus.eop_o  = eop_r;
  assign bus.val_o  = val_r;
  assign bus.busy_o = busy_r;

  always_ff @(posedge clk_i or negedge srst_i) begin
    if (!srst_i) begin
      state   <= RECV;
      cnt     <= '0;
      idx     <= '0;
      open    <= 1'b0;
      swapped <= 1'b0;
      data_r  <= '0;
      sop_r   <= 1'b0;
      eop_r   <= 1'b0;
      val_r   <= 1'b0;
      busy_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      data_r <= '0;
      sop_r  <= 1'b0;
      eop_r  <= 1'b0;
      val_r  <= 1'b0;
      case (state)
        RECV: begin
          if (bus.val_i) begin
            unique case (1'b1)
              bus.sop_i: begin
                mem[0] <= bus.data_i;
                cnt    <= ONE;
                open   <= !bus.eop_i;
                if (bus.eop_i) begin
                  state   <= SORT;
                  busy_r  <= 1'b1;
                  idx     <= '0;
                  swapped <= 1'b0;
                end
              end
              open: begin
                // words beyond capacity are dropped, eop still closes
                if (cnt != N_MAX) begin
                  mem[cnt[AWIDTH-1:0]] <= bus.data_i;
                  cnt <= cnt + ONE;
                end
                if (bus.eop_i) begin
                  open    <= 1'b0;
                  state   <= SORT;
                  busy_r  <= 1'b1;
                  idx     <= '0;
                  swapped <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        SORT: begin
          if (cnt <= ONE) begin
            state <= SEND;
            idx   <= '0;
          end else begin
            if (swap) begin
              mem[idx[AWIDTH-1:0]]   <= hi_w;
              mem[idx_n[AWIDTH-1:0]] <= lo_w;
            end
            if (last) begin
              idx     <= '0;
              swapped <= 1'b0;
              // a full pass without swaps means the array is ordered
              if (!(swapped || swap)) begin
                state <= SEND;
              end
            end else begin
              idx     <= idx_n;
              swapped <= swapped || swap;
            end
          end
        end
        SEND: begin
          if (idx == cnt) begin
            busy_r <= 1'b0;
            state  <= RECV;
            cnt    <= '0;
            idx    <= '0;
          end else begin
            val_r  <= 1'b1;
            data_r <= mem[idx[AWIDTH-1:0]];
            sop_r  <= idx == '0;
            eop_r  <= idx_n == cnt;
            idx    <= idx_n;
          end
        end
        default: state <= RECV;
      endcase
    end
  end
endmodule

// File: tb/tb_sorting_core.sv
// Directed bench for sorting_core: queue-based reference of sorted
// output beats checked on every falling edge.
module tb_sorting_core;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } beat_t;

  logic clk = 1'b0;
  logic srst = 1'b0;
  always #5 clk = ~clk;

  sorting_core_if #(.DWIDTH(8)) bus ();

  sorting_core #(.DWIDTH(8), .AWIDTH(3)) dut (
    .clk_i (clk),
    .srst_i(srst),
    .bus   (bus)
  );

  int    vecs = 0;
  int    errs = 0;
  int    cyc = 0;
  int    eop_cyc = 0;
  int    pend_n = 0;
  beat_t exp_q[$];
  bit    in_burst = 0;
  bit    chk_idle = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic bq_t model_sort(input bq_t w);
    bq_t r;
    logic [7:0] t;
    for (int i = 0; i < w.size() && i < 8; i++) r.push_back(w[i]);
    for (int i = 0; i < r.size(); i++)
      for (int j = 0; j + 1 < r.size() - i; j++)
        if (r[j] > r[j+1]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
    return r;
  endfunction

  always @(negedge clk) begin
    beat_t b;
    int lat;
    if (!srst) begin
      in_burst = 0;
      chk_idle = 0;
      chk("rst_out", {bus.val_o, bus.sop_o, bus.eop_o,
                      bus.busy_o, bus.data_o}, 0);
    end else if (bus.val_o) begin
      chk("busy_on_val", bus.busy_o, 1);
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_val: data %0h", bus.data_o);
      end else begin
        b = exp_q.pop_front();
        chk("data", bus.data_o, b.d);
        chk("sop", bus.sop_o, b.s);
        chk("eop", bus.eop_o, b.e);
      end
      if (bus.sop_o) begin
        lat = cyc - eop_cyc;
        chk("latency_ok", (lat >= 1 && lat <= pend_n * pend_n + 4), 1);
        in_burst = 1;
      end
      if (bus.eop_o) begin
        in_burst = 0;
        chk_idle = 1;
      end
    end else begin
      if (bus.sop_o || bus.eop_o || bus.data_o != 0)
        chk("idle_zero", {bus.sop_o, bus.eop_o, bus.data_o}, 0);
      if (in_burst) begin
        chk("burst_gap", bus.val_o, 1);
        in_burst = 0;
      end
      if (chk_idle) begin
        chk("busy_fall", bus.busy_o, 0);
        chk_idle = 0;
      end
    end
  end

  task automatic send_pkt(input bq_t w, input bit live);
    bq_t s;
    beat_t b;
    if (live) begin
      s = model_sort(w);
      for (int i = 0; i < s.size(); i++) begin
        b.d = s[i];
        b.s = (i == 0);
        b.e = (i == s.size() - 1);
        exp_q.push_back(b);
      end
      pend_n = s.size();
    end
    for (int i = 0; i < w.size(); i++) begin
      @(posedge clk);
      #1;
      bus.val_i  = 1'b1;
      bus.data_i = w[i];
      bus.sop_i  = (i == 0);
      bus.eop_i  = (i == w.size() - 1);
      if (live && i == w.size() - 1) eop_cyc = cyc + 1;
    end
    @(posedge clk);
    #1;
    bus.val_i = 1'b0;
    bus.sop_i = 1'b0;
    bus.eop_i = 1'b0;
    bus.data_i = 8'h00;
    if (live) chk("busy_rise", bus.busy_o, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy_o) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_in_time", n < 300, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bq_t q;
    bq_t r;
    int n;
    bus.val_i = 1'b0;
    bus.sop_i = 1'b0;
    bus.eop_i = 1'b0;
    bus.data_i = 8'h00;

    q = '{8'hA3, 8'h15, 8'hF0, 8'h15};
    r = model_sort(q);
    chk("pin_sort4", {r[0], r[1], r[2], r[3]}, 32'h1515A3F0);
    q = '{8'h0A, 8'h09, 8'h08, 8'h07, 8'h06,
          8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    r = model_sort(q);
    chk("pin_ovf_len", r.size(), 8);
    chk("pin_ovf_ends", {r[0], r[7]}, 16'h030A);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {bus.val_o, bus.sop_o, bus.eop_o,
                        bus.busy_o, bus.data_o}, 0);
    srst = 1'b1;
    @(posedge clk);
    #1;

    // stray beat without sop is ignored
    bus.val_i = 1'b1;
    bus.data_i = 8'hEE;
    @(posedge clk);
    #1;
    bus.val_i = 1'b0;
    send_pkt('{8'hA3, 8'h15, 8'hF0, 8'h15}, 1);
    wait_idle();

    send_pkt('{8'h7E}, 1);
    wait_idle();

    send_pkt('{8'h08, 8'h07, 8'h06, 8'h05,
               8'h04, 8'h03, 8'h02, 8'h01}, 1);
    wait_idle();

    send_pkt('{8'h0A, 8'h09, 8'h08, 8'h07, 8'h06,
               8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 1);
    wait_idle();

    // packet offered while busy is lost
    send_pkt('{8'h40, 8'h30, 8'h20, 8'h10}, 1);
    send_pkt('{8'h55, 8'h44}, 0);
    wait_idle();
    send_pkt('{8'h02, 8'h01}, 1);
    wait_idle();

    // reset in the middle of the output burst
    send_pkt('{8'h04, 8'h03, 8'h02, 8'h01}, 1);
    n = 0;
    while (!bus.val_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_started", n < 100, 1);
    @(posedge clk);
    #1;
    srst = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_imm", {bus.val_o, bus.sop_o, bus.eop_o,
                    bus.busy_o, bus.data_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    srst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", {bus.val_o, bus.busy_o}, 0);
    send_pkt('{8'h09, 8'h03}, 1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/sorting_core.md
# sorting_core

Packet sorter in the streaming datapath. Accepts one packet of up to 2**AWIDTH words framed by sop/eop, stores it, and sorts it in ascending unsigned order. It then emits the sorted packet with the same framing. While sorting or emitting, it reports busy and ignores its input.

## Interface
- DWIDTH, 8, data word width in bits (unsigned).
- AWIDTH, 3, address width; max packet length N_MAX = 2**AWIDTH words.
- clk_i  in  1  single clock; all logic on rising edge.
- srst_i  in  1  reset, asynchronous, active-low.
- data_i  in  DWIDTH  input word, qualified by val_i.
- sop_i  in  1  first word of packet, qualified by val_i.
- eop_i  in  1  last word of packet, qualified by val_i.
- val_i  in  1  input word valid.
- data_o  out  DWIDTH  sorted output word; driven 0 when val_o=0.
- sop_o  out  1  first output word.
- eop_o  out  1  last output word.
- val_o  out  1  output word valid.
- busy_o  out  1  block is sorting or emitting; input ignored.

## Operation
- States: RECV, SORT, SEND. Reset state is RECV.
- Storage: array of N_MAX x DWIDTH, plus a word counter of AWIDTH+1 bits.
- RECV, no packet open:
  - Beats with val_i=1 and sop_i=0 are ignored.
  - A beat with val_i=1 and sop_i=1 opens a packet and stores the word at index 0.
- RECV, packet open: each val_i=1 beat stores the next word.
- sop_i=1 on an open packet discards the stored words and restarts the packet with the current word.
- Overflow: once N_MAX words are stored, further words are dropped. The packet stays open until eop.
- eop_i=1 with val_i=1 stores its word (if room) and closes the packet. Go to SORT with N = stored count, 1 <= N <= N_MAX.
- A single-word packet has sop_i and eop_i in the same beat.
- sop_i and eop_i are ignored when val_i=0.
- SORT:
  - In-place ascending sort of indices 0..N-1, e.g. bubble sort with one compare-swap per cycle.
  - Duplicates are preserved.
  - Go to SEND when done.
- SEND:
  - Emit indices 0..N-1 on consecutive cycles with val_o=1.
  - sop_o=1 with index 0; eop_o=1 with index N-1. Both are 1 when N=1.
  - Return to RECV after the eop_o beat.
- All inputs are ignored in SORT and SEND. This includes sop_i: a packet sent while busy is lost.
- srst_i low at any time:
  - Immediate return to RECV with no packet open.
  - Counter cleared, stored data discarded.
  - Any partial output stops; no further val_o.

## Timing
- Reset values: val_o=0, sop_o=0, eop_o=0, data_o=0, busy_o=0.
- Input words are sampled on the rising edge where val_i=1.
- busy_o rises on the first cycle after the edge that accepted eop.
- busy_o stays 1 through the cycle carrying eop_o, and is 0 on the following cycle. A new sop can be accepted on that cycle.
- busy_o, val_o, sop_o, eop_o and data_o are registered outputs.
- Latency: first val_o no later than N*N+4 cycles after the eop edge. The first val_o is at least 1 cycle after that edge.
- Output burst: exactly N consecutive val_o cycles, with no gaps.
- val_o=0 outside SEND; sop_o and eop_o are never 1 while val_o=0.

## Test plan
- Reset then 4-word packet 0xA3, 0x15, 0xF0, 0x15 (sop on word 1, eop on word 4):
  - Output 0x15, 0x15, 0xA3, 0xF0, contiguous.
  - sop_o on the first word, eop_o on the last.
  - busy_o=1 from the cycle after eop until the eop_o cycle.
- Single word 0x7E with sop_i=eop_i=val_i=1 -> one output beat 0x7E with sop_o=eop_o=val_o=1.
- Full packet 8 words descending 0x08..0x01:
  - Output 0x01..0x08.
  - First val_o within 68 cycles of eop.
- Overflow: 10-word packet 0x0A..0x01 with eop on word 10:
  - Only the first 8 words are kept; output 0x03..0x0A (8 beats).
  - Last word dropped, but its eop closes the packet.
- Input while busy: a packet 0x55, 0x44 sent during SORT/SEND produces no output. Then a packet 0x02, 0x01 after busy_o falls outputs 0x01, 0x02.
- Reset mid-operation: assert srst_i low during SEND of a 4-word packet:
  - All outputs go to 0 immediately; no further val_o.
  - A following packet 0x09, 0x03 sorts to 0x03, 0x09.
